// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;

  localparam int WORD_W = 16;
  localparam int CNT_W  = 3;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } fsmState_t;

  // Misaligned, or word index beyond the 2^wordsLog2 array.
  function automatic logic isBadAddr(input logic [15:0] addr, input int wordsLog2);
    logic [14:0] wordIdx;
    wordIdx = addr[15:1];
    return addr[0] || ((wordIdx >> wordsLog2) != 15'd0);
  endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction word array: synchronous write, asynchronous read, contents not reset.
module imem_array
  import imem_pkg::*;
#(
  parameter int MEM_WORDS_LOG2 = 10
) (
  input  logic                      clk,
  input  logic                      wrEn,
  input  logic [MEM_WORDS_LOG2-1:0] wrIdx,
  input  logic [WORD_W-1:0]         wrData,
  input  logic [MEM_WORDS_LOG2-1:0] rdIdx,
  output logic [WORD_W-1:0]         rdData
);

  logic [WORD_W-1:0] mem [0:(1<<MEM_WORDS_LOG2)-1];

  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[wrIdx] <= wrData;
    end
  end

  assign rdData = mem[rdIdx];

endmodule

// File: rtl/imem_responder.sv
// Memory side of the fetch interface: one outstanding read, fixed latency,
// error reporting, flush cancellation and a gated preload write port.
module imem_responder
  import imem_pkg::*;
#(
  parameter int LATENCY        = 3,
  parameter int MEM_WORDS_LOG2 = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [15:0] req_addr,
  output logic        req_ready,
  input  logic        flush,
  output logic        resp_valid,
  output logic [15:0] resp_data,
  output logic        resp_err,
  input  logic        wr_en,
  input  logic [15:0] wr_addr,
  input  logic [15:0] wr_data
);

  localparam logic [CNT_W-1:0] BUSY_LOAD    = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;
  localparam fsmState_t        ACCEPT_STATE = (LATENCY == 1) ? RESP : BUSY;

  fsmState_t         stateReg, stateNext;
  logic [CNT_W-1:0]  cntReg, cntNext;
  logic [WORD_W-1:0] dataReg, dataNext;
  logic              errReg, errNext;
  logic              accept;
  logic              reqErr;
  logic              arrayWrEn;
  logic [WORD_W-1:0] rdWord;
  logic              unusedWrAddr;

  // Writes only when no read could be in progress or starting this cycle.
  assign arrayWrEn    = wr_en && (stateReg == IDLE) && !req_valid && !flush;
  assign reqErr       = isBadAddr(req_addr, MEM_WORDS_LOG2);
  assign unusedWrAddr = ^wr_addr;

  imem_array #(
    .MEM_WORDS_LOG2(MEM_WORDS_LOG2)
  ) u_array (
    .clk   (clk),
    .wrEn  (arrayWrEn),
    .wrIdx (wr_addr[MEM_WORDS_LOG2:1]),
    .wrData(wr_data),
    .rdIdx (req_addr[MEM_WORDS_LOG2:1]),
    .rdData(rdWord)
  );

  always_comb begin
    stateNext  = stateReg;
    cntNext    = cntReg;
    dataNext   = dataReg;
    errNext    = errReg;
    req_ready  = rst && ((stateReg != BUSY) || flush);
    resp_valid = (stateReg == RESP) && !flush;
    accept     = req_valid && req_ready;

    case (stateReg)
      IDLE: ;
      BUSY: begin
        if (cntReg == '0) begin
          stateNext = RESP;
        end else begin
          cntNext = cntReg - 1'b1;
        end
      end
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase

    if (flush) begin
      stateNext = IDLE;
      cntNext   = '0;
    end

    // A fresh acceptance overrides both the normal walk and a flush.
    if (accept) begin
      stateNext = ACCEPT_STATE;
      cntNext   = BUSY_LOAD;
      errNext   = reqErr;
      dataNext  = reqErr ? '0 : rdWord;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateReg <= IDLE;
      cntReg   <= '0;
      dataReg  <= '0;
      errReg   <= 1'b0;
    end else begin
      stateReg <= stateNext;
      cntReg   <= cntNext;
      dataReg  <= dataNext;
      errReg   <= errNext;
    end
  end

  assign resp_data = dataReg;
  assign resp_err  = errReg;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder with LATENCY=3 and a 1024-word array.
module tb_imem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [15:0] req_addr;
  logic        req_ready;
  logic        flush;
  logic        resp_valid;
  logic [15:0] resp_data;
  logic        resp_err;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;

  int passCnt  = 0;
  int totalCnt = 0;

  always #5 clk = ~clk;

  imem_responder #(
    .LATENCY       (3),
    .MEM_WORDS_LOG2(10)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .flush     (flush),
    .resp_valid(resp_valid),
    .resp_data (resp_data),
    .resp_err  (resp_err),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic doRead(input string tag, input logic [15:0] a,
                        input logic [15:0] expData, input logic expErr);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = a;
    #1 chk({tag, "_ready_T"}, 16'(req_ready), 16'd1);
    @(negedge clk);
    req_valid = 1'b0;
    #1 chk({tag, "_valid_T1"}, 16'(resp_valid), 16'd0);
    @(negedge clk);
    #1 chk({tag, "_valid_T2"}, 16'(resp_valid), 16'd0);
    @(negedge clk);
    #1;
    chk({tag, "_valid_T3"}, 16'(resp_valid), 16'd1);
    chk({tag, "_data"}, resp_data, expData);
    chk({tag, "_err"}, 16'(resp_err), 16'(expErr));
    @(negedge clk);
    #1;
    chk({tag, "_valid_T4"}, 16'(resp_valid), 16'd0);
    chk({tag, "_ready_idle"}, 16'(req_ready), 16'd1);
  endtask

  initial begin
    rst       = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    flush     = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 16'(req_ready), 16'd0);
    chk("rst_valid", 16'(resp_valid), 16'd0);
    chk("rst_data", resp_data, 16'h0000);
    chk("rst_err", 16'(resp_err), 16'd0);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("rel_ready", 16'(req_ready), 16'd1);

    preload(16'h0010, 16'hA5C3);
    preload(16'h0000, 16'h1111);
    preload(16'h0002, 16'h2222);
    preload(16'h0004, 16'h3333);
    preload(16'h0020, 16'h1234);
    preload(16'h07FE, 16'hBEEF);

    // Array contents must survive a reset pulse
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    doRead("basic", 16'h0010, 16'hA5C3, 1'b0);

    // Back-to-back: new address presented in each RESP cycle
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 16'h0000;
    @(negedge clk);
    req_addr = 16'h0002;
    #1;
    chk("b2b_busy_ready", 16'(req_ready), 16'd0);
    chk("b2b_busy_valid", 16'(resp_valid), 16'd0);
    @(negedge clk);
    #1 chk("b2b_valid0_T2", 16'(resp_valid), 16'd0);
    @(negedge clk);
    #1;
    chk("b2b_valid0", 16'(resp_valid), 16'd1);
    chk("b2b_data0", resp_data, 16'h1111);
    chk("b2b_ready_resp", 16'(req_ready), 16'd1);
    @(negedge clk);
    req_addr = 16'h0004;
    #1;
    chk("b2b_busy1_ready", 16'(req_ready), 16'd0);
    chk("b2b_busy1_valid", 16'(resp_valid), 16'd0);
    @(negedge clk);
    #1 chk("b2b_valid1_T2", 16'(resp_valid), 16'd0);
    @(negedge clk);
    #1;
    chk("b2b_valid1", 16'(resp_valid), 16'd1);
    chk("b2b_data1", resp_data, 16'h2222);
    @(negedge clk);
    req_valid = 1'b0;
    #1 chk("b2b_busy2_valid", 16'(resp_valid), 16'd0);
    @(negedge clk);
    #1 chk("b2b_valid2_T2", 16'(resp_valid), 16'd0);
    @(negedge clk);
    #1;
    chk("b2b_valid2", 16'(resp_valid), 16'd1);
    chk("b2b_data2", resp_data, 16'h3333);
    @(negedge clk);
    #1 chk("b2b_after_valid", 16'(resp_valid), 16'd0);

    // Error cases and the last legal word
    doRead("misalign", 16'h0011, 16'h0000, 1'b1);
    doRead("range", 16'h0800, 16'h0000, 1'b1);
    doRead("lastword", 16'h07FE, 16'hBEEF, 1'b0);

    // Flush in BUSY together with a new request
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 16'h0010;
    @(negedge clk);
    req_valid = 1'b0;
    #1 chk("fb_busy_ready", 16'(req_ready), 16'd0);
    @(negedge clk);
    flush     = 1'b1;
    req_valid = 1'b1;
    req_addr  = 16'h0020;
    #1;
    chk("fb_flush_ready", 16'(req_ready), 16'd1);
    chk("fb_flush_valid", 16'(resp_valid), 16'd0);
    @(negedge clk);
    flush     = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("fb_old_suppressed", 16'(resp_valid), 16'd0);
    chk("fb_restart_ready", 16'(req_ready), 16'd0);
    @(negedge clk);
    #1 chk("fb_valid_T2", 16'(resp_valid), 16'd0);
    @(negedge clk);
    #1;
    chk("fb_valid_T3", 16'(resp_valid), 16'd1);
    chk("fb_data", resp_data, 16'h1234);
    chk("fb_err", 16'(resp_err), 16'd0);
    @(negedge clk);
    #1 chk("fb_valid_T4", 16'(resp_valid), 16'd0);

    // Flush during the RESP cycle
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 16'h0000;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    #1;
    chk("fr_valid_masked", 16'(resp_valid), 16'd0);
    chk("fr_ready", 16'(req_ready), 16'd1);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("fr_idle_valid", 16'(resp_valid), 16'd0);
    chk("fr_idle_ready", 16'(req_ready), 16'd1);

    // Preload write while BUSY is dropped
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 16'h0002;
    @(negedge clk);
    req_valid = 1'b0;
    wr_en     = 1'b1;
    wr_addr   = 16'h0010;
    wr_data   = 16'hDEAD;
    @(negedge clk);
    wr_en = 1'b0;
    @(negedge clk);
    #1;
    chk("iw_valid", 16'(resp_valid), 16'd1);
    chk("iw_data", resp_data, 16'h2222);
    doRead("iw_reread", 16'h0010, 16'hA5C3, 1'b0);

    // Reset asserted while BUSY
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 16'h0004;
    @(negedge clk);
    req_valid = 1'b0;
    #1 chk("mr_busy_data", resp_data, 16'h3333);
    rst = 1'b0;
    #1;
    chk("mr_ready", 16'(req_ready), 16'd0);
    chk("mr_valid", 16'(resp_valid), 16'd0);
    chk("mr_data", resp_data, 16'h0000);
    chk("mr_err", 16'(resp_err), 16'd0);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("mr_rel_ready", 16'(req_ready), 16'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1 chk($sformatf("mr_no_resp_%0d", i), 16'(resp_valid), 16'd0);
    end
    doRead("post_reset", 16'h0004, 16'h3333, 1'b0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
